// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the instruction fetch sequencer: FSM encoding,
// instruction geometry and the queue entry layout.
package fetch_sequencer_pkg;

    localparam int INST_W     = 32;
    localparam int INST_BYTES = 4;

    localparam logic [1:0] ST_FETCH  = 2'd0;
    localparam logic [1:0] ST_HALTED = 2'd1;
    localparam logic [1:0] ST_FAULT  = 2'd2;

    typedef struct packed {
        logic [INST_W-1:0] word;
        logic [INST_W-1:0] pc;
    } fetch_entry_t;

    // Word-align an address and fold it into the instruction memory window.
    function automatic logic [31:0] wrap_align(input logic [31:0] addr,
                                               input logic [31:0] mem_bytes);
        return addr & (mem_bytes - 32'd1) & ~(32'(INST_BYTES) - 32'd1);
    endfunction

endpackage

// File: rtl/fetch_sequencer_queue.sv
// Parameterised synchronous FIFO buffering fetched {word, pc} entries.
// Flush empties the queue and overrides any push/pop in the same cycle.
module fetch_queue
    import fetch_sequencer_pkg::*;
#(
    parameter  int DEPTH = 2,
    parameter  int WIDTH = 2 * INST_W,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] head_data,
    output logic             head_valid,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             pop_s;
    logic             push_s;

    // A push into a full queue is accepted only when the head leaves this cycle.
    assign pop_s  = pop && (count_r != {CW{1'b0}});
    assign push_s = push && ((count_r < CW'(DEPTH)) || pop_s);

    // Storage, pointers and occupancy.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r <= count_r + CW'(push_s) - CW'(pop_s);
        end
    end

    assign head_valid = (count_r != {CW{1'b0}});
    assign head_data  = head_valid ? mem_r[rd_ptr_r] : {WIDTH{1'b0}};
    assign count      = count_r;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: PC/address generation, latency wait, redirect
// and halt handling. Optional FETCH_ADDR_CHECK_EN traps illegal redirect targets.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          MEM_BYTES   = 256,
    parameter int          MEM_LATENCY = 1,
    parameter int          QUEUE_DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        halt_req,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic        halted,
    output logic        fault
);

    localparam int              CNT_W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);
    localparam int              QCW      = $clog2(QUEUE_DEPTH) + 1;
    localparam logic [31:0]     MEM_SIZE = 32'(MEM_BYTES);

    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic [31:0]      pc_r;
    logic [31:0]      pc_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             push_s;
    logic             pop_s;
    logic             flush_s;
    logic             space_s;
    logic             target_bad_s;
    logic [QCW-1:0]   count_s;
    fetch_entry_t     head_s;
    fetch_entry_t     push_entry_s;

    assign pop_s        = inst_valid && inst_ready;
    assign space_s      = (count_s < QCW'(QUEUE_DEPTH)) || pop_s;
    assign push_entry_s = '{word: imem_data, pc: pc_r};

`ifdef FETCH_ADDR_CHECK_EN
    assign target_bad_s = (redirect_target[1:0] != 2'b00) || (redirect_target >= MEM_SIZE);
`else
    assign target_bad_s = 1'b0;
`endif

    // Next-state, PC and latency counter; redirect overrides everything but FAULT.
    always_comb begin
        state_nxt_s = state_r;
        pc_nxt_s    = pc_r;
        cnt_nxt_s   = cnt_r;
        push_s      = 1'b0;
        flush_s     = 1'b0;
        if (redirect_valid && (state_r != ST_FAULT)) begin
            flush_s   = 1'b1;
            cnt_nxt_s = {CNT_W{1'b0}};
            if (target_bad_s) begin
                state_nxt_s = ST_FAULT;
            end else begin
                state_nxt_s = ST_FETCH;
                pc_nxt_s    = wrap_align(redirect_target, MEM_SIZE);
            end
        end else begin
            case (state_r)
                ST_FETCH: begin
                    if (halt_req) begin
                        state_nxt_s = ST_HALTED;
                        cnt_nxt_s   = {CNT_W{1'b0}};
                    end else if (cnt_r == CNT_LAST) begin
                        if (space_s) begin
                            push_s    = 1'b1;
                            pc_nxt_s  = wrap_align(pc_r + 32'(INST_BYTES), MEM_SIZE);
                            cnt_nxt_s = {CNT_W{1'b0}};
                        end else begin
                            cnt_nxt_s = cnt_r;
                        end
                    end else begin
                        cnt_nxt_s = cnt_r + CNT_W'(1);
                    end
                end
                ST_HALTED: state_nxt_s = ST_HALTED;
                ST_FAULT:  state_nxt_s = ST_FAULT;
                default: begin
                    state_nxt_s = ST_FETCH;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                    flush_s     = 1'b1;
                end
            endcase
        end
    end

    // FSM, PC and latency counter registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_FETCH;
            pc_r    <= RESET_PC;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            pc_r    <= pc_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_queue (
        .clock      (clock),
        .reset_n    (reset_n),
        .push       (push_s),
        .pop        (pop_s),
        .flush      (flush_s),
        .push_data  (push_entry_s),
        .head_data  (head_s),
        .head_valid (inst_valid),
        .count      (count_s)
    );

    assign imem_addr = pc_r;
    assign inst      = head_s.word;
    assign inst_pc   = head_s.pc;
    assign halted    = (state_r == ST_HALTED);
`ifdef FETCH_ADDR_CHECK_EN
    assign fault     = (state_r == ST_FAULT);
`else
    assign fault     = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomised and directed bench for fetch_sequencer against a queue-based
// reference model of fetch, redirect, halt and (optionally) fault behaviour.
module tb_fetch_sequencer;

    localparam int MEM_BYTES   = 256;
    localparam int MEM_LATENCY = 1;
    localparam int QUEUE_DEPTH = 2;

    logic        clock;
    logic        reset_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        halt_req;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic        halted;
    logic        fault;

    logic [7:0]  mem_b [MEM_BYTES];
    logic [7:0]  a_s;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state
    int unsigned  m_pc;
    int unsigned  m_wait;
    logic [63:0]  m_q [$];
    bit           m_halted;
    bit           m_fault;

    fetch_sequencer #(
        .RESET_PC    (32'h0000_0000),
        .MEM_BYTES   (MEM_BYTES),
        .MEM_LATENCY (MEM_LATENCY),
        .QUEUE_DEPTH (QUEUE_DEPTH)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .imem_addr       (imem_addr),
        .imem_data       (imem_data),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .halt_req        (halt_req),
        .inst            (inst),
        .inst_pc         (inst_pc),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .halted          (halted),
        .fault           (fault)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Big-endian memory, readable within the same cycle as the address.
    assign a_s       = imem_addr[7:0];
    assign imem_data = {mem_b[a_s], mem_b[a_s + 8'd1], mem_b[a_s + 8'd2], mem_b[a_s + 8'd3]};

    function automatic logic [31:0] mem_word(input int unsigned a);
        return {mem_b[a], mem_b[a + 1], mem_b[a + 2], mem_b[a + 3]};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc     = 0;
        m_wait   = 0;
        m_q.delete();
        m_halted = 0;
        m_fault  = 0;
    endtask

    // One rising edge of the reference behaviour, using the current inputs.
    task automatic model_edge();
        bit          pop;
        bit          bad;
        int unsigned t;
        pop = (m_q.size() != 0) && inst_ready;
        if (redirect_valid && !m_fault) begin
            t = redirect_target;
            m_q.delete();
            m_wait   = 0;
            m_halted = 0;
            bad      = 0;
`ifdef FETCH_ADDR_CHECK_EN
            bad = (t % 4 != 0) || (t >= MEM_BYTES);
`endif
            if (bad) m_fault = 1;
            else     m_pc = (t - t % 4) % MEM_BYTES;
        end else begin
            if (pop) void'(m_q.pop_front());
            if (!m_halted && !m_fault) begin
                if (halt_req) begin
                    m_halted = 1;
                    m_wait   = 0;
                end else if (m_wait == MEM_LATENCY - 1) begin
                    if (m_q.size() < QUEUE_DEPTH) begin
                        m_q.push_back({mem_word(m_pc), m_pc[31:0]});
                        m_pc   = (m_pc + 4) % MEM_BYTES;
                        m_wait = 0;
                    end
                end else begin
                    m_wait++;
                end
            end
        end
    endtask

    task automatic compare_all();
        bit          v;
        logic [63:0] h;
        v = (m_q.size() != 0);
        h = v ? m_q[0] : 64'd0;
        check_eq("imem_addr",  imem_addr,  m_pc);
        check_eq("inst_valid", inst_valid, v);
        check_eq("inst",       inst,       h[63:32]);
        check_eq("inst_pc",    inst_pc,    h[31:0]);
        check_eq("halted",     halted,     m_halted);
        check_eq("fault",      fault,      m_fault);
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        @(negedge clock);
        compare_all();
    endtask

    // Asserted at a negedge (mid-cycle) so the asynchronous clear is observed.
    task automatic do_reset();
        reset_n        = 1'b0;
        redirect_valid = 1'b0;
        halt_req       = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic redirect_to(input logic [31:0] t);
        redirect_valid  = 1'b1;
        redirect_target = t;
        step();
        redirect_valid  = 1'b0;
    endtask

    initial begin
        reset_n         = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'd0;
        halt_req        = 1'b0;
        inst_ready      = 1'b0;
        for (int i = 0; i < MEM_BYTES; i++) mem_b[i] = 8'($urandom);
        model_reset();
        @(negedge clock);
        @(negedge clock);
        compare_all();

        // Back-to-back fetch from reset
        inst_ready = 1'b1;
        reset_n    = 1'b1;
        step(); check_eq("t1_pc0", inst_pc, 32'h0); check_eq("t1_w0", inst, mem_word(0));
        step(); check_eq("t1_pc4", inst_pc, 32'h4); check_eq("t1_w4", inst, mem_word(4));
        step(); check_eq("t1_pc8", inst_pc, 32'h8);
        step(); check_eq("t1_pc12", inst_pc, 32'hC);

        // Backpressure fills the queue, then drains without gap or duplicate
        @(negedge clock);
        do_reset();
        inst_ready = 1'b0;
        repeat (5) step();
        check_eq("t2_addr_hold", imem_addr, 32'h8);
        check_eq("t2_head", inst_pc, 32'h0);
        inst_ready = 1'b1;
        step(); check_eq("t2_pc4", inst_pc, 32'h4);
        step(); check_eq("t2_pc8", inst_pc, 32'h8);

        // Redirect flushes a full queue; misaligned target is aligned
        inst_ready = 1'b0;
        redirect_to(32'h10);
        repeat (3) step();
        check_eq("t3_full_head", inst_pc, 32'h10);
        redirect_to(32'h40);
        check_eq("t3_flushed", inst_valid, 1'b0);
        inst_ready = 1'b1;
        step(); check_eq("t3_pc40", inst_pc, 32'h40);
`ifndef FETCH_ADDR_CHECK_EN
        redirect_to(32'h43);
        check_eq("t3_align_addr", imem_addr, 32'h40);
        step(); check_eq("t3_align_pc", inst_pc, 32'h40);
`endif

        // Wrap at the top of memory
        redirect_to(32'hF8);
        step(); check_eq("t4_pc248", inst_pc, 32'd248);
        step(); check_eq("t4_pc252", inst_pc, 32'd252);
        step(); check_eq("t4_pc0", inst_pc, 32'd0);
        step(); check_eq("t4_pc4", inst_pc, 32'd4);

        // Halt: queue drains, no new pushes, redirect resumes
        inst_ready = 1'b0;
        redirect_to(32'h18);
        repeat (2) step();
        halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        check_eq("t5_halted", halted, 1'b1);
        check_eq("t5_addr", imem_addr, 32'h20);
        inst_ready = 1'b1;
        step(); check_eq("t5_drain", inst_pc, 32'h1C);
        step(); check_eq("t5_empty", inst_valid, 1'b0);
        step(); check_eq("t5_nopush", inst_valid, 1'b0);
        redirect_to(32'h8);
        check_eq("t5_resume", halted, 1'b0);
        step(); check_eq("t5_pc8", inst_pc, 32'h8);

`ifdef FETCH_ADDR_CHECK_EN
        redirect_to(32'h100);
        check_eq("t6_fault", fault, 1'b1);
        check_eq("t6_novalid", inst_valid, 1'b0);
        repeat (3) step();
        redirect_to(32'h10);
        check_eq("t6_sticky", fault, 1'b1);
        @(negedge clock);
        do_reset();
`endif

        // Random traffic with one mid-run reset
        for (int i = 0; i < 600; i++) begin
            inst_ready      = ($urandom_range(0, 3) != 0);
            halt_req        = ($urandom_range(0, 31) == 0);
            redirect_valid  = ($urandom_range(0, 15) == 0);
            redirect_target = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 63) * 4);
            if (i == 300 || (m_fault && $urandom_range(0, 19) == 0)) begin
                do_reset();
            end else begin
                step();
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
